expand_input: RTL and testbench
===============================

// Module: expand_input
// PURPOSE
// - Inverse of the sparse output compactor: takes a packed vector of up to 16 nonzero values plus a
//   16-bit occupancy mask and scatters the values back to their dense positions, zero-filling the rest.
// - Sits on the input side of a compute tile. It restores dense activations from compressed storage
//   before they feed the MAC/softmax datapath.
// - Same 3-state IDLE/BUSY/DONE handshake as the other sparsity blocks.
// PARAMETERS
// - IL  4   integer bits of each signed fixed-point element
// - FL  16  fractional bits of each element; element width W = IL+FL
// PORTS
// - clk           in   1        rising-edge clock; single clock domain
// - reset         in   1        synchronous, active-low reset (reset==0 resets on the clk edge)
// - i_packed      in   W x16    packed nonzero values; entry 0 is the lowest set mask position
// - i_mask        in   16       bit k=1: dense position k holds the next packed value
// - input_ready   in   1        upstream offers i_packed/i_mask; sampled only in IDLE
// - output_taken  in   1        downstream consumed o_im; sampled only in DONE
// - o_im          out  W x16    dense reconstructed vector (signed)
// - o_count       out  5        popcount(i_mask) captured at accept, range 0..16
// - state         out  2        00 IDLE, 01 BUSY, 10 DONE; 11 is never entered
// BEHAVIOUR
// - Reset (reset==0): state=00; o_im all 0; o_count=0; internal pointers and captured regs = 0.
// - Reset overrides every other event, including mid-BUSY. The in-flight vector is discarded.
// - Accept: state==00 && input_ready==1 at an edge.
//   - Registers i_packed and i_mask, clears o_im to 0, loads o_count.
//   - Zeroes o_ptr (dense index) and i_ptr (packed index); state -> 01.
// - input_ready is ignored in BUSY and DONE. Inputs may change after accept without effect.
// - BUSY, one dense position per cycle:
//   - if mask_r[o_ptr]: o_im[o_ptr] <= packed_r[i_ptr]; i_ptr <= i_ptr+1.
//   - otherwise o_im[o_ptr] stays 0.
//   - o_ptr <= o_ptr+1 in either case.
// - Completion: the BUSY edge that processes o_ptr==15 also sets state -> 10.
//   - BUSY lasts exactly 16 cycles; DONE is visible on cycle 17 after the accept edge.
// - DONE: o_im and o_count hold stable. output_taken==1 -> state 00. o_im is retained in IDLE
//   until the next accept clears it.
// - output_taken outside DONE is ignored.
// - Packed entries at index >= popcount(mask) are never read. i_ptr saturates at 16 and never wraps.
// - Arithmetic: values are copied bit-exact, with no rescaling or sign change.
// - A packed value of 0 under a set mask bit is written as 0 and still advances i_ptr.
// - mask=16'h0000: every o_im stays 0, o_count=0. mask=16'hFFFF: o_im[k]=packed[k] for all k.
// CONFIGURATION
// - Macro EXPAND_EARLY_DONE_EN.
//   - Defined: BUSY ends on the first edge where o_ptr==15 or mask_r[15:o_ptr+1]==0, after the
//     write for o_ptr. Remaining positions are already 0 from the accept clear.
//   - With the macro defined, mask=0 gives 1 BUSY cycle and mask=16'h0001 gives 1 BUSY cycle.
//   - Undefined: fixed 16-cycle BUSY for every mask.
// - o_im contents are identical with and without the macro; only the timing of state differs.
// STRUCTURE
// - Shared package sparsity_pkg:
//   - typedef enum logic[1:0] {ST_IDLE=2'b00, ST_BUSY=2'b01, ST_DONE=2'b10} sp_state_t;
//   - localparam VEC_LEN=16; localparam PTR_W=4.
// - One sub-module, mask_popcount16: combinational 16-bit popcount with a 5-bit result.
//   It is instanced once, for o_count.
// - Top: FSM, capture registers, two pointers, scatter write, optional early-done compare.
// TESTING
// - Reset with reset=0 for 2 cycles, then 1.
//   -> state=00, o_im all 0, o_count=0; input_ready=0 held keeps state=00.
// - mask=16'h8421, packed[0..3]=1,2,3,4 (raw ints).
//   -> o_im[0]=1, [5]=2, [10]=3, [15]=4, others 0; o_count=4; DONE 17 cycles after accept.
// - mask=16'hFFFF, packed[k]=-k-1 (signed).
//   -> o_im[k]=-k-1 for all k; o_count=16.
// - mask=16'h0000 -> all 0; o_count=0. With EXPAND_EARLY_DONE_EN: DONE on cycle 2.
//   Without it: DONE on cycle 17.
// - reset=0 asserted on BUSY cycle 8 of the mask=16'hFFFF run.
//   -> next cycle state=00, o_im all 0. A new accept then completes normally.
// - In DONE, hold output_taken=0 for 5 cycles while toggling input_ready.
//   -> state stays 10, o_im unchanged. Then output_taken=1 -> state 00 and o_im retained.

Source files
------------

// File: rtl/sparsity_pkg.sv
// Shared types for the sparsity blocks: handshake state encoding and vector geometry.
// Used by expand_input; no feature macros.
package sparsity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } sp_state_t;

  localparam int VEC_LEN = 16;
  localparam int PTR_W   = 4;

endpackage

// File: rtl/expand_input_if.sv
// Bus between the compressed-storage side and the dense tile input: packed values, mask,
// IDLE/BUSY/DONE handshake and the reconstructed dense vector.
interface expand_input_if
  import sparsity_pkg::*;
#(
  parameter int W = 20
);

  logic [VEC_LEN-1:0][W-1:0] i_packed;
  logic [VEC_LEN-1:0]        i_mask;
  logic                      input_ready;
  logic                      output_taken;
  logic [VEC_LEN-1:0][W-1:0] o_im;
  logic [PTR_W:0]            o_count;
  logic [1:0]                state;

  modport master (
    output i_packed, i_mask, input_ready, output_taken,
    input  o_im, o_count, state
  );

  modport slave (
    input  i_packed, i_mask, input_ready, output_taken,
    output o_im, o_count, state
  );

endinterface

// File: rtl/mask_popcount16.sv
// Combinational population count of a 16-bit occupancy mask; result spans 0..16.
module mask_popcount16 (
  input  logic [15:0] mask_i,
  output logic [4:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int k = 0; k < 16; k++) begin
      count_o = count_o + {4'b0000, mask_i[k]};
    end
  end

endmodule

// File: rtl/expand_input.sv
// Scatters up to 16 packed values back to their dense positions, one position per BUSY cycle.
// EXPAND_EARLY_DONE_EN: leave BUSY once no set mask bits remain above the current position.
module expand_input
  import sparsity_pkg::*;
#(
  parameter int IL = 4,
  parameter int FL = 16
)(
  input  logic          clk,
  input  logic          reset,
  expand_input_if.slave bus
);

  localparam int W = IL + FL;

  sp_state_t                 state_q, state_d;
  logic [VEC_LEN-1:0][W-1:0] packed_q, packed_d;
  logic [VEC_LEN-1:0]        mask_q, mask_d;
  logic [VEC_LEN-1:0][W-1:0] o_im_q, o_im_d;
  logic [PTR_W:0]            o_count_q, o_count_d;
  logic [PTR_W-1:0]          o_ptr_q, o_ptr_d;
  logic [PTR_W:0]            i_ptr_q, i_ptr_d;

  logic [PTR_W:0]            mask_cnt;
  logic                      last_pos;

  mask_popcount16 u_popcount (
    .mask_i  (bus.i_mask),
    .count_o (mask_cnt)
  );

  // Decides whether the position being written this cycle is the final one.
`ifdef EXPAND_EARLY_DONE_EN
  logic [VEC_LEN-1:0] mask_above;

  always_comb begin
    mask_above = mask_q >> ({1'b0, o_ptr_q} + 5'd1);
    last_pos   = (o_ptr_q == PTR_W'(VEC_LEN - 1)) || (mask_above == '0);
  end
`else
  always_comb begin
    last_pos = (o_ptr_q == PTR_W'(VEC_LEN - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      packed_q  <= '0;
      mask_q    <= '0;
      o_im_q    <= '0;
      o_count_q <= '0;
      o_ptr_q   <= '0;
      i_ptr_q   <= '0;
    end else begin
      state_q   <= state_d;
      packed_q  <= packed_d;
      mask_q    <= mask_d;
      o_im_q    <= o_im_d;
      o_count_q <= o_count_d;
      o_ptr_q   <= o_ptr_d;
      i_ptr_q   <= i_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    packed_d  = packed_q;
    mask_d    = mask_q;
    o_im_d    = o_im_q;
    o_count_d = o_count_q;
    o_ptr_d   = o_ptr_q;
    i_ptr_d   = i_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.input_ready) begin
          packed_d  = bus.i_packed;
          mask_d    = bus.i_mask;
          o_im_d    = '0;
          o_count_d = mask_cnt;
          o_ptr_d   = '0;
          i_ptr_d   = '0;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Unset positions keep the zero written at accept; i_ptr never passes 16.
        if (mask_q[o_ptr_q]) begin
          o_im_d[o_ptr_q] = packed_q[i_ptr_q[PTR_W-1:0]];
          if (i_ptr_q != 5'(VEC_LEN)) begin
            i_ptr_d = i_ptr_q + 5'd1;
          end
        end
        o_ptr_d = o_ptr_q + 4'd1;
        if (last_pos) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.output_taken) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_im    = o_im_q;
  assign bus.o_count = o_count_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_expand_input.sv
// Directed, table-driven bench for expand_input plus hand-written reset and DONE-hold sequences.
module tb_expand_input;

  localparam int IL = 4;
  localparam int FL = 16;
  localparam int W  = IL + FL;
  localparam int NV = 6;

  typedef struct {
    logic [15:0]        mask;
    logic [15:0][W-1:0] pk;
    logic [15:0][W-1:0] exp_im;
    int                 exp_cnt;
    int                 lat_full;   // accept edge counted as cycle 1
    int                 lat_early;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  expand_input_if #(.W(W)) bus();

  expand_input #(.IL(IL), .FL(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  vec_t vecs [NV];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input bit take);
    int cyc;
    int exp_lat;
`ifdef EXPAND_EARLY_DONE_EN
    exp_lat = vecs[idx].lat_early;
`else
    exp_lat = vecs[idx].lat_full;
`endif
    bus.i_packed    = vecs[idx].pk;
    bus.i_mask      = vecs[idx].mask;
    bus.input_ready = 1'b1;
    tick();
    // Inputs scrambled after accept must have no effect.
    bus.input_ready = 1'b0;
    bus.i_packed    = ~vecs[idx].pk;
    bus.i_mask      = ~vecs[idx].mask;
    chk($sformatf("busy_after_accept v%0d", idx), 32'(bus.state), 32'd1);
    chk($sformatf("clear_on_accept v%0d", idx), 32'(|bus.o_im), 32'd0);
    cyc = 1;
    while (bus.state != 2'b10 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk($sformatf("done_latency v%0d", idx), 32'(cyc), 32'(exp_lat));
    chk($sformatf("o_count v%0d", idx), 32'(bus.o_count), 32'(vecs[idx].exp_cnt));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("o_im[%0d] v%0d", k, idx), 32'(bus.o_im[k]), 32'(vecs[idx].exp_im[k]));
    end
    if (take) begin
      bus.output_taken = 1'b1;
      tick();
      bus.output_taken = 1'b0;
      chk($sformatf("idle_after_take v%0d", idx), 32'(bus.state), 32'd0);
      chk($sformatf("retained_in_idle v%0d", idx), 32'(bus.o_im == vecs[idx].exp_im), 32'd1);
    end
  endtask

  initial begin
    logic [15:0][W-1:0] held;

    // Fill the vector table; entries beyond popcount carry junk that must never appear.
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < 16; k++) vecs[v].pk[k] = 20'hABCDE ^ W'(k * 20'h01111);
      vecs[v].exp_im   = '0;
      vecs[v].lat_full = 17;
    end

    vecs[0].mask = 16'h8421;
    vecs[0].pk[0] = 20'd1; vecs[0].pk[1] = 20'd2; vecs[0].pk[2] = 20'd3; vecs[0].pk[3] = 20'd4;
    vecs[0].exp_im[0] = 20'd1; vecs[0].exp_im[5] = 20'd2;
    vecs[0].exp_im[10] = 20'd3; vecs[0].exp_im[15] = 20'd4;
    vecs[0].exp_cnt = 4; vecs[0].lat_early = 17;

    vecs[1].mask = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      vecs[1].pk[k]     = W'(-(k + 1));
      vecs[1].exp_im[k] = W'(-(k + 1));
    end
    vecs[1].exp_cnt = 16; vecs[1].lat_early = 17;

    vecs[2].mask = 16'h0000;
    vecs[2].exp_cnt = 0; vecs[2].lat_early = 2;

    vecs[3].mask = 16'h0001;
    vecs[3].pk[0] = 20'h80000;
    vecs[3].exp_im[0] = 20'h80000;
    vecs[3].exp_cnt = 1; vecs[3].lat_early = 2;

    // Zero value under a set bit still consumes a packed slot.
    vecs[4].mask = 16'h00F0;
    vecs[4].pk[0] = 20'h00000; vecs[4].pk[1] = 20'h7FFFF;
    vecs[4].pk[2] = 20'h00001; vecs[4].pk[3] = 20'hFFFFF;
    vecs[4].exp_im[4] = 20'h00000; vecs[4].exp_im[5] = 20'h7FFFF;
    vecs[4].exp_im[6] = 20'h00001; vecs[4].exp_im[7] = 20'hFFFFF;
    vecs[4].exp_cnt = 4; vecs[4].lat_early = 9;

    vecs[5].mask = 16'h8000;
    vecs[5].pk[0] = 20'h00042;
    vecs[5].exp_im[15] = 20'h00042;
    vecs[5].exp_cnt = 1; vecs[5].lat_early = 17;

    // Reset sequence
    reset            = 1'b0;
    bus.input_ready  = 1'b0;
    bus.output_taken = 1'b0;
    bus.i_packed     = '0;
    bus.i_mask       = '0;
    tick();
    tick();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_o_im", 32'(|bus.o_im), 32'd0);
    chk("reset_o_count", 32'(bus.o_count), 32'd0);
    reset = 1'b1;
    bus.output_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_hold %0d", i), 32'(bus.state), 32'd0);
    end
    bus.output_taken = 1'b0;

    for (int v = 0; v < NV; v++) begin
      run_vec(v, 1'b1);
    end

    // Reset on BUSY cycle 8 of the dense run
    bus.i_packed    = vecs[1].pk;
    bus.i_mask      = vecs[1].mask;
    bus.input_ready = 1'b1;
    tick();
    bus.input_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy_state", 32'(bus.state), 32'd1);
    chk("mid_busy_partial", 32'(bus.o_im[6]), 32'(vecs[1].exp_im[6]));
    reset = 1'b0;
    tick();
    chk("mid_reset_state", 32'(bus.state), 32'd0);
    chk("mid_reset_o_im", 32'(|bus.o_im), 32'd0);
    chk("mid_reset_o_count", 32'(bus.o_count), 32'd0);
    reset = 1'b1;
    run_vec(0, 1'b1);

    // DONE holds while output_taken stays low
    run_vec(4, 1'b0);
    held = vecs[4].exp_im;
    for (int i = 0; i < 5; i++) begin
      bus.input_ready = i[0];
      bus.i_mask      = 16'(16'h1357 * (i + 1));
      tick();
      chk($sformatf("done_hold_state %0d", i), 32'(bus.state), 32'd2);
      chk($sformatf("done_hold_o_im %0d", i), 32'(bus.o_im == held), 32'd1);
    end
    bus.input_ready  = 1'b0;
    bus.output_taken = 1'b1;
    tick();
    bus.output_taken = 1'b0;
    chk("take_state", 32'(bus.state), 32'd0);
    chk("take_retained", 32'(bus.o_im == held), 32'd1);
    chk("take_count", 32'(bus.o_count), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
